// File: rtl/div_iter_pkg.sv
// Shared state codes and handshake constants for the iterative divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// Combinational restoring-division slice: BITS_PER_CYCLE shift/trial-subtract steps, MSB first.
module div_iter_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH:0]          rem_in,
  input  logic [BITS_PER_CYCLE-1:0] dvd_bits,
  input  logic [WIDTH-1:0]        divisor,
  output logic [WIDTH:0]          rem_out,
  output logic [BITS_PER_CYCLE-1:0] q_bits
);

  logic [WIDTH:0]   r;
  logic [WIDTH+1:0] trial;

  // rem_in is always below the divisor, so the shifted value fits in WIDTH+1 bits
  always_comb begin
    q_bits = '0;
    r      = rem_in;
    trial  = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      trial = {r, dvd_bits[i]} - {2'b00, divisor};
      if (!trial[WIDTH+1]) begin
        r         = trial[WIDTH:0];
        q_bits[i] = 1'b1;
      end else begin
        r = {r[WIDTH-1:0], dvd_bits[i]};
      end
    end
    rem_out = r;
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider; result_o = {remainder, quotient}, held until the next DONE.
//   state    | meaning
//   DIV_IDLE | waiting for start_i
//   DIV_CALC | resolving BITS_PER_CYCLE quotient bits per cycle
//   DIV_DONE | one-cycle ready_o pulse, result_o valid
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  div_state_e state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem;
  logic             neg_q, neg_r;

  logic [WIDTH:0]            rem_nxt;
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]          dq_nxt, q_fix, r_fix;
  logic                      a_neg, b_neg, last;
  logic [WIDTH-1:0]          a_mag, b_mag;

  div_iter_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in   (rem),
    .dvd_bits (dq[WIDTH-1 -: BITS_PER_CYCLE]),
    .divisor  (dsr),
    .rem_out  (rem_nxt),
    .q_bits   (q_bits)
  );

  // dq holds the unconsumed dividend bits on top and the quotient bits shifting in below
  assign dq_nxt = (dq << BITS_PER_CYCLE) | WIDTH'(q_bits);
  assign q_fix  = neg_q ? -dq_nxt : dq_nxt;
  assign r_fix  = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
  assign last   = (cnt == CW'(1));

  assign a_neg = signed_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_i & opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start_i == DIV_START)
                  state_nxt = (opdata2_i == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (annul_i)   state_nxt = DIV_IDLE;
                else if (last) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      dq            <= '0;
      dsr           <= '0;
      rem           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start_i == DIV_START) begin
          if (opdata2_i == '0) begin
            result_o      <= {opdata1_i, {WIDTH{1'b1}}};
            div_by_zero_o <= 1'b1;
          end else begin
            dq    <= a_mag;
            dsr   <= b_mag;
            rem   <= '0;
            cnt   <= CW'(N);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        DIV_CALC: if (annul_i) begin
          cnt <= '0;
        end else begin
          dq  <= dq_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            result_o      <= {r_fix, q_fix};
            div_by_zero_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy_o  = (state == DIV_CALC);

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative integer divider for the EX stage: accepts a dividend/divisor pair with a start strobe and computes quotient and remainder, signed or unsigned, at a configurable number of quotient bits per cycle. It supports abort via annul, flags division by zero in a single cycle, and holds its result until the next accepted start. EX drives it from its stall logic: it raises the EX stall request while a start is pending and ready is low.

## Interface
- WIDTH, 32: operand width; must be ≥ 4 and divisible by BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1: quotient bits resolved per CALC cycle; legal values are 1, 2 and 4.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in IDLE (`DivStart/`DivStop).
- signed_i  in  1  1 = two's-complement division, 0 = unsigned; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- annul_i  in  1  abort the operation in flight.
- result_o  out  2*WIDTH  {remainder, quotient}, i.e. HI in the upper half and LO in the lower half.
- ready_o  out  1  one-cycle pulse: result_o is valid (`DivResultReady).
- busy_o  out  1  high while in CALC.
- div_by_zero_o  out  1  qualifies the last result; valid while result_o is held.

## Operation
- States are IDLE, CALC and DONE.
- IDLE + start_i + divisor≠0 → CALC.
  - Latch |dividend| and |divisor|; take absolute values only when signed_i=1.
  - Latch the sign bits and signed_i.
  - Clear the partial remainder; load the counter with N = WIDTH/BITS_PER_CYCLE.
- IDLE + start_i + divisor=0 → DONE.
  - quotient = all ones; remainder = dividend, raw and unmodified.
  - div_by_zero_o = 1.
- CALC, per cycle: BITS_PER_CYCLE restoring steps, MSB first. For each step:
  - Shift the remainder left, bringing in the next dividend bit.
  - Trial-subtract the divisor.
  - Keep the difference when the trial is non-negative and set that quotient bit to 1.
- CALC, each cycle: decrement the counter; when it reaches 0, go to DONE. Sign fix-up is applied on that transition:
  - quotient is negated if the signs differ and signed_i=1;
  - remainder is negated if the dividend was negative and signed_i=1;
  - div_by_zero_o = 0.
- DONE → IDLE unconditionally after one cycle. start_i is ignored in DONE.
- annul_i in CALC → IDLE next edge.
  - No ready_o pulse; result_o and div_by_zero_o keep their previous values.
  - If the final CALC cycle coincides with annul_i, annul wins.
  - annul_i in IDLE or DONE has no effect.
- start_i while in CALC or DONE is ignored; the inputs are not re-sampled.
- Arithmetic:
  - The unsigned magnitude of the most negative value, 2^(WIDTH-1), fits in WIDTH bits.
  - MIN / −1 wraps: quotient = MIN, remainder = 0. No overflow flag.
  - The remainder register is WIDTH+1 bits wide internally, for the trial subtraction.
- Reset (resetn=0, at any time including mid-CALC):
  - state=IDLE and counter=0;
  - result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0;
  - the in-flight operation is lost.

## Timing
- The start edge is cycle 0, the cycle in which start_i is high in IDLE.
- Normal division: busy_o is high in cycles 1..N and ready_o is high in cycle N+1 only.
  - WIDTH=32, BITS_PER_CYCLE=1: ready in cycle 33.
  - WIDTH=32, BITS_PER_CYCLE=4: ready in cycle 9.
- Divide by zero: ready_o in cycle 1; busy_o is never high.
- Earliest next start is cycle N+2, i.e. the first IDLE cycle after DONE.
- Back-to-back operation: the EX caller drops start_i in the cycle ready_o is high. Any start_i still high in the next IDLE cycle begins a new operation.
- result_o and div_by_zero_o are registered and stable from ready_o until the next DONE or reset. They are never modified during CALC.
- ready_o and busy_o are decoded from state registers only, with no combinational path from inputs.
- After annul in cycle k, busy_o is low in cycle k+1 and a new start is accepted in cycle k+1.

## Structure
- `lib/defines.vh` gains `DivIdle`, `DivCalc` and `DivDone` (2-bit state codes) alongside the existing `DivStart`, `DivStop`, `DivResultReady` and `DivResultNotReady`.
- Sub-module div_iter_step: combinational, parametrised by WIDTH and BITS_PER_CYCLE.
  - Inputs: partial remainder, dividend bits, divisor.
  - Outputs: next remainder and the new quotient bits.
  - div_iter instantiates it once.
- The sign handling and the state/counter logic stay in div_iter.

## Test plan
- Unsigned 100/7, WIDTH=32, BPC=1: result_o={32'd2, 32'd14}, ready_o only in cycle 33, busy_o high in cycles 1..32.
- Signed −7/2 (0xFFFFFFF9 / 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- 5/0 (both modes): ready_o in cycle 1, result_o={32'd5, 32'hFFFFFFFF}, div_by_zero_o=1. A following 9/3 clears div_by_zero_o and gives quotient 3, remainder 0.
- annul_i in cycle 10 of 100/7: busy_o low in cycle 11, no ready_o pulse, result_o unchanged. A start in cycle 11 of 20/6 gives quotient 3, remainder 2, with ready in cycle 44.
- resetn low for 1 cycle in cycle 15 of a division: all outputs 0 immediately, state is IDLE, no ready_o pulse follows.
- BPC=4 and BPC=2 with random operands: results match the reference model and ready_o arrives in cycle WIDTH/BPC+1. Verify the unsigned 0xFFFFFFFF/1 case explicitly.
